alu_issue: RTL

- Two-stage issue/retire block that drives the RV32I ALU's operand and op-select inputs and consumes its result/zero outputs.
- Decodes an instruction word plus register-file operands into ALU operands and a 4-bit ALU op, then presents them to the ALU.
- Captures the ALU response into a writeback/branch result register.
- Sits between decode/register-read and writeback/PC-update. Uses valid/ready handshakes on both sides, throughput 1 instr/cycle.

---
 rtl/alu_issue_if.sv | 54 +++++
 rtl/alu_issue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle of the upstream issue handshake, the ALU operand/response
// pair and the downstream result handshake used by alu_issue.
// ALU_ISSUE_ILLEGAL_TRAP_EN adds the o_res_illegal flag to the result side.
interface alu_issue_if;
    // Upstream (decode / register read)
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    // ALU side
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [3:0]  o_alu_op;
    logic [31:0] i_alu_result;
    logic        i_alu_zero;
    // Downstream (writeback / PC update)
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_res_data;
    logic [4:0]  o_res_rd;
    logic        o_res_we;
    logic        o_res_is_branch;
    logic        o_res_taken;
    logic [31:0] o_res_target;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic        o_res_illegal;
`endif

    // Block side
    modport slave (
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        output o_res_illegal,
`endif
        input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data,
        input  i_alu_result, i_alu_zero, i_res_ready,
        output o_ready, o_alu_a, o_alu_b, o_alu_op,
        output o_res_valid, o_res_data, o_res_rd, o_res_we,
        output o_res_is_branch, o_res_taken, o_res_target
    );

    // Environment side (upstream, ALU and downstream together)
    modport master (
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        input  o_res_illegal,
`endif
        output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data,
        output i_alu_result, i_alu_zero, i_res_ready,
        input  o_ready, o_alu_a, o_alu_b, o_alu_op,
        input  o_res_valid, o_res_data, o_res_rd, o_res_we,
        input  o_res_is_branch, o_res_taken, o_res_target
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/retire block around the RV32I ALU.
// Stage 1 holds decoded operands/op presented to the ALU; stage 2 captures the
// ALU response as a writeback/branch result. Full-pipeline stall, no skid buffer.
// Optional: ALU_ISSUE_ILLEGAL_TRAP_EN carries illegal instructions through as
// flagged no-write entries; without it they are accepted and dropped.
module alu_issue #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] RESET_PC_TGT = 32'h0000_0000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_BNE  = 4'b1111;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1011;
    localparam logic [3:0] ALU_BLTU = 4'b1010;
    localparam logic [3:0] ALU_BGEU = 4'b1001;

    // Instruction fields and immediates
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] shamt;

    assign opc   = bus.i_instr[6:0];
    assign rd    = bus.i_instr[11:7];
    assign f3    = bus.i_instr[14:12];
    assign f7    = bus.i_instr[31:25];
    assign imm_i = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
    assign imm_u = {bus.i_instr[31:12], 12'b0};
    assign imm_b = {{19{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                    bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
    assign shamt = {27'b0, bus.i_instr[24:20]};

    // Decoded stage-1 payload
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [XLEN-1:0] dec_tgt;
    logic [3:0]      dec_op;
    logic            dec_br;
    logic            dec_ill;
    logic            dec_we;

    // Stage-1 registers (drive the ALU)
    logic            vld_p1;
    logic [XLEN-1:0] a_p1;
    logic [XLEN-1:0] b_p1;
    logic [3:0]      op_p1;
    logic [4:0]      rd_p1;
    logic            we_p1;
    logic            br_p1;
    logic [XLEN-1:0] tgt_p1;

    // Stage-2 registers (result)
    logic            vld_p2;
    logic [XLEN-1:0] data_p2;
    logic [4:0]      rd_p2;
    logic            we_p2;
    logic            br_p2;
    logic            taken_p2;
    logic [XLEN-1:0] tgt_p2;

    // Handshake
    logic ready;
    logic accept;
    logic load_p1;
    logic adv;

    assign ready   = !vld_p1 || !vld_p2 || bus.i_res_ready;
    assign accept  = bus.i_valid && ready;
    assign adv     = vld_p1 && (!vld_p2 || bus.i_res_ready);
    assign dec_we  = !dec_ill && !dec_br && (rd != 5'd0);
    assign dec_tgt = bus.i_pc + imm_b;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic ill_p1;
    logic ill_p2;
    assign load_p1           = accept;
    assign bus.o_res_illegal = ill_p2;
`else
    assign load_p1 = accept && !dec_ill;
`endif

    // Decode instruction word into ALU operands, op select and legality
    always_comb begin
        dec_a   = bus.i_rs1_data;
        dec_b   = bus.i_rs2_data;
        dec_op  = ALU_ADD;
        dec_br  = 1'b0;
        dec_ill = 1'b0;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    dec_op = {1'b0, f3};
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec_op = {1'b1, f3};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_IMM: begin
                dec_b = imm_i;
                case (f3)
                    3'b000: dec_op = ALU_ADD;
                    3'b001: begin
                        dec_b   = shamt;
                        dec_op  = ALU_SLL;
                        dec_ill = (f7 != F7_ZERO);
                    end
                    3'b101: begin
                        dec_b = shamt;
                        if (f7 == F7_ZERO) begin
                            dec_op = ALU_SRL;
                        end else if (f7 == F7_ALT) begin
                            dec_op = ALU_SRA;
                        end else begin
                            dec_ill = 1'b1;
                        end
                    end
                    default: dec_op = {1'b0, f3};
                endcase
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = bus.i_pc;
                dec_b = imm_u;
            end
            OPC_BR: begin
                dec_br = 1'b1;
                case (f3)
                    3'b000:  dec_op = ALU_SUB;   // BEQ: zero flag of a-b
                    3'b001:  dec_op = ALU_BNE;
                    3'b100:  dec_op = ALU_BLT;
                    3'b101:  dec_op = ALU_BGE;
                    3'b110:  dec_op = ALU_BLTU;
                    3'b111:  dec_op = ALU_BGEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_br = 1'b0;
        end
    end

    // Stage 1: capture decoded instruction on accept, empty when it advances
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= ALU_ADD;
            rd_p1  <= '0;
            we_p1  <= 1'b0;
            br_p1  <= 1'b0;
            tgt_p1 <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            ill_p1 <= 1'b0;
`endif
        end else begin
            if (load_p1) begin
                vld_p1 <= 1'b1;
            end else if (adv) begin
                vld_p1 <= 1'b0;
            end
            if (load_p1) begin
                a_p1   <= dec_a;
                b_p1   <= dec_b;
                op_p1  <= dec_op;
                rd_p1  <= rd;
                we_p1  <= dec_we;
                br_p1  <= dec_br;
                tgt_p1 <= dec_tgt;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                ill_p1 <= dec_ill;
`endif
            end
        end
    end

    // Stage 2: capture ALU response with stage-1 fields; hold while stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p2   <= 1'b0;
            data_p2  <= '0;
            rd_p2    <= '0;
            we_p2    <= 1'b0;
            br_p2    <= 1'b0;
            taken_p2 <= 1'b0;
            tgt_p2   <= RESET_PC_TGT;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            ill_p2   <= 1'b0;
`endif
        end else begin
            if (adv) begin
                vld_p2 <= 1'b1;
            end else if (bus.i_res_ready) begin
                vld_p2 <= 1'b0;
            end
            if (adv) begin
                data_p2  <= bus.i_alu_result;
                rd_p2    <= rd_p1;
                we_p2    <= we_p1;
                br_p2    <= br_p1;
                taken_p2 <= br_p1 && bus.i_alu_zero;
                tgt_p2   <= tgt_p1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                ill_p2   <= ill_p1;
`endif
            end
        end
    end

    assign bus.o_ready         = ready;
    assign bus.o_alu_a         = a_p1;
    assign bus.o_alu_b         = b_p1;
    assign bus.o_alu_op        = op_p1;
    assign bus.o_res_valid     = vld_p2;
    assign bus.o_res_data      = data_p2;
    assign bus.o_res_rd        = rd_p2;
    assign bus.o_res_we        = we_p2;
    assign bus.o_res_is_branch = br_p2;
    assign bus.o_res_taken     = taken_p2;
    assign bus.o_res_target    = tgt_p2;
endmodule
